apb_reg_bank: RTL and testbench
===============================

# apb_reg_bank

Parametrised APB slave register bank; successor to the fixed four-register ALU configuration block. It supports a configurable register count, data width, base address and wait-state count, plus byte strobes and per-register write pulses. It sits between the APB interconnect and the ALU datapath, which consumes the register contents through a flat parallel bus.

## Interface
- DATA_WIDTH, 32: register and bus data width; multiple of 8.
- ADDR_WIDTH, 32: paddr width.
- NUM_REGS, 4: number of RW registers, 1..64; word-spaced (stride 4).
- BASE_ADDR, 32'h0000_0010: address of register 0; 4-byte aligned.
- WAIT_STATES, 0: extra ACCESS cycles before pready, 0..15.
- RESET_VALUE, 0: reset value of every register.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- pstrb  in  DATA_WIDTH/8  byte write strobes.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer completion.
- pslverr  out  1  transfer error.
- regs_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_pulse  out  NUM_REGS  one-cycle pulse the cycle after reg i is written.

## Operation
- Decode:
  - offset = paddr - BASE_ADDR; idx = offset >> 2.
  - hit = (paddr >= BASE_ADDR) && (offset[1:0] == 0) && (idx < NUM_REGS).
- FSM states IDLE and ACCESS, plus a 4-bit wait counter cnt.
  - IDLE: on a clock edge with psel=1 and penable=0 (setup phase), go to ACCESS and set cnt=0.
  - ACCESS, psel=0: abort to IDLE. No write occurs, wr_pulse stays 0.
  - ACCESS, psel=1, cnt<WAIT_STATES: cnt increments.
  - ACCESS, psel=1, cnt==WAIT_STATES: completion cycle; return to IDLE.
  - psel=1 with penable=1 seen in IDLE is ignored (no setup phase); the FSM stays in IDLE.
- pready = (state==ACCESS) && psel && penable && (cnt==WAIT_STATES). Combinational from registered state.
- Write: commits at the completion edge when pwrite=1 and hit.
  - Byte k of reg idx is updated only where pstrb[k]=1.
  - pstrb all zero means no change, but wr_pulse still fires.
- Read: prdata = reg[idx] during the completion cycle when pwrite=0 and hit; prdata = 0 at all other times.
- Miss (hit=0): the write is dropped, the read returns 0, and wr_pulse does not fire.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted, since the FSM is already in IDLE.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, cnt=0.
  - All registers = RESET_VALUE.
  - pready=0, pslverr=0, prdata=0, wr_pulse=0.
  - A transfer in flight is discarded.
- Transfer length is setup + (1 + WAIT_STATES) access cycles. With WAIT_STATES=0, pready is high in the first access cycle.
- regs_out reflects a write one cycle after the completion edge. wr_pulse[idx] is high in that same cycle, for exactly one cycle.
- paddr, pwrite, pwdata and pstrb must be stable from setup through completion. They are sampled only in the completion cycle.

## Configuration
- APB_REG_BANK_PSLVERR_EN defined:
  - pslverr = pready && !hit.
  - A misaligned or out-of-range transfer completes normally, with pslverr=1 for that completion cycle only.
- Macro undefined:
  - pslverr is tied 0.
  - Misses complete silently: write dropped, read returns 0.

## Test plan
All scenarios use NUM_REGS=4, BASE_ADDR=0x10, DATA_WIDTH=32, WAIT_STATES=2.

- Reset, then read 0x10, 0x14, 0x18 and 0x1C.
  - Each returns 0x0000_0000.
  - pready is high exactly 3 cycles after setup.
- Write 0xDEAD_BEEF to 0x14 with pstrb=4'b1111, then read back.
  - Read returns 0xDEAD_BEEF.
  - wr_pulse=4'b0010 for one cycle.
  - regs_out[63:32]=0xDEAD_BEEF.
- Write 0x1122_3344 to 0x18 with pstrb=4'b0101 over a prior value of 0xAAAA_AAAA.
  - Read returns 0xAA22_AA44.
- Write 0x5 to 0x20, then to 0x12.
  - All registers are unchanged and no wr_pulse fires.
  - With the macro defined, pslverr=1 in each completion cycle; without it, pslverr stays 0.
- Drop psel after 1 ACCESS cycle of a write of 0x1234 to 0x10.
  - reg0 is unchanged, pready never rises, and the FSM is back in IDLE.
- Assert reset for 1 cycle during the wait count of a write to 0x1C.
  - reg3=0, outputs go to their reset values, and the next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_bank.sv
// apb_reg_bank: parametrised APB slave register bank feeding the ALU datapath.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   reset     - asynchronous active-high reset
//   psel      - APB select
//   penable   - APB enable
//   pwrite    - 1 = write, 0 = read
//   paddr     - byte address (ADDR_WIDTH)
//   pwdata    - write data (DATA_WIDTH)
//   pstrb     - byte write strobes (DATA_WIDTH/8)
//   prdata    - read data, non-zero only in a read completion cycle that hits
//   pready    - transfer completion (combinational from registered state)
//   pslverr   - transfer error
//   regs_out  - flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_pulse  - one-cycle pulse the cycle after reg i is written
//
// Optional feature macro: APB_REG_BANK_PSLVERR_EN
//   defined   - pslverr flags completions that miss the register window
//   undefined - pslverr tied 0, misses complete silently
module apb_reg_bank #(
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           NUM_REGS    = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0000_0010),
    parameter int unsigned           WAIT_STATES = 0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           psel,
    input  logic                           penable,
    input  logic                           pwrite,
    input  logic [ADDR_WIDTH-1:0]          paddr,
    input  logic [DATA_WIDTH-1:0]          pwdata,
    input  logic [DATA_WIDTH/8-1:0]        pstrb,
    output logic [DATA_WIDTH-1:0]          prdata,
    output logic                           pready,
    output logic                           pslverr,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(WAIT_STATES);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                 pulse_q, pulse_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  hit;
    logic                  wr_commit;
    logic                  rd_commit;

    // Address decode against the word-spaced register window
    assign offset = paddr - BASE_ADDR;
    assign idx    = offset >> 2;
    assign hit    = (paddr >= BASE_ADDR) && (offset[1:0] == 2'b00) &&
                    (idx < ADDR_WIDTH'(NUM_REGS));

    // Completion: access phase with the wait count exhausted
    assign pready    = (state_q == S_ACCESS) && psel && penable && (cnt_q == CNT_LAST);
    assign wr_commit = pready && pwrite && hit;
    assign rd_commit = pready && !pwrite && hit;

`ifdef APB_REG_BANK_PSLVERR_EN
    assign pslverr = pready && !hit;
`else
    assign pslverr = 1'b0;
`endif

    // FSM state and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: setup phase opens ACCESS; psel drop aborts; count to completion
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                if (!psel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_LAST) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Byte-strobed register update; the pulse fires on any hit write, even with no strobes
    always_comb begin
        regs_d  = regs_q;
        pulse_d = '0;
        if (wr_commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (idx == ADDR_WIDTH'(i)) begin
                    pulse_d[i] = 1'b1;
                    for (int unsigned k = 0; k < STRB_WIDTH; k++) begin
                        if (pstrb[k]) begin
                            regs_d[i][k*8 +: 8] = pwdata[k*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Register storage and write pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q  <= {NUM_REGS{RESET_VALUE}};
            pulse_q <= '0;
        end else begin
            regs_q  <= regs_d;
            pulse_q <= pulse_d;
        end
    end

    // Read mux, zero outside a hitting read completion
    always_comb begin
        prdata = '0;
        if (rd_commit) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (idx == ADDR_WIDTH'(i)) begin
                    prdata = regs_q[i];
                end
            end
        end
    end

    assign regs_out = regs_q;
    assign wr_pulse = pulse_q;

endmodule

// File: tb/tb_apb_reg_bank.sv
// Self-checking bench for apb_reg_bank (NUM_REGS=4, BASE_ADDR=0x10, DATA_WIDTH=32, WAIT_STATES=2).
module tb_apb_reg_bank;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned NR    = 4;
    localparam int unsigned WS    = 2;
    localparam int unsigned BASE  = 32'h10;

    logic              clk;
    logic              reset;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic [DW/8-1:0]   pstrb;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;
    logic [NR*DW-1:0]  regs_out;
    logic [NR-1:0]     wr_pulse;

    apb_reg_bank #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR),
        .BASE_ADDR  (32'h10),
        .WAIT_STATES(WS),
        .RESET_VALUE(32'h0)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr),
        .regs_out(regs_out),
        .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: plain array of register words
    logic [31:0] m_regs [NR];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = m_regs[i];
        return f;
    endfunction

    function automatic bit model_hit(input int unsigned addr);
        if (addr < BASE) return 1'b0;
        if ((addr % 4) != 0) return 1'b0;
        return ((addr - BASE) / 4) < NR;
    endfunction

    function automatic logic exp_err(input bit h);
`ifdef APB_REG_BANK_PSLVERR_EN
        return !h;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    endtask

    // Full transfer; entered #1 after an edge, returns #1 after the edge following completion
    // with psel still high so a back-to-back setup may follow directly.
    task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                            input logic [3:0] strb, input string tag);
        bit           h;
        int unsigned  id;
        int unsigned  cycles;
        bit           done;
        logic [31:0]  rd;
        logic         err;
        logic [31:0]  exp_rd;
        logic [3:0]   exp_pulse;
        h  = model_hit(addr);
        id = h ? (addr - BASE) / 4 : 0;
        exp_rd    = (h && !wr) ? m_regs[id] : 32'h0;
        exp_pulse = (h && wr) ? 4'(1 << id) : 4'h0;

        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb;
        check({tag, "/setup_pready"}, 128'(pready), 128'(0));
        @(posedge clk); #1;
        penable = 1'b1;
        check({tag, "/pulse_clear"}, 128'(wr_pulse), 128'(0));
        cycles = 1; done = 0; rd = '0; err = 1'b0;
        while (!done && cycles <= 16) begin
            if (pready) begin
                done = 1; rd = prdata; err = pslverr;
            end else begin
                if (prdata !== 32'h0) check({tag, "/prdata_idle"}, 128'(prdata), 128'(0));
                @(posedge clk); #1;
                cycles++;
            end
        end
        check({tag, "/completed"}, 128'(done), 128'(1));
        check({tag, "/cycles"}, 128'(cycles), 128'(WS + 1));
        check({tag, "/prdata"}, 128'(rd), 128'(exp_rd));
        check({tag, "/pslverr"}, 128'(err), 128'(exp_err(h)));

        if (h && wr) begin
            for (int k = 0; k < 4; k++)
                if (strb[k]) m_regs[id][k*8 +: 8] = wdata[k*8 +: 8];
        end
        @(posedge clk); #1;
        check({tag, "/wr_pulse"}, 128'(wr_pulse), 128'(exp_pulse));
        check({tag, "/regs_out"}, 128'(regs_out), model_flat());
    endtask

    task automatic bus_idle(input int n);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check("idle/wr_pulse", 128'(wr_pulse), 128'(0));
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic        w;
        int unsigned tok;
        reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        model_reset();
        @(posedge clk); #1;
        check("rst/pready", 128'(pready), 128'(0));
        check("rst/pslverr", 128'(pslverr), 128'(0));
        check("rst/prdata", 128'(prdata), 128'(0));
        check("rst/wr_pulse", 128'(wr_pulse), 128'(0));
        check("rst/regs_out", 128'(regs_out), 128'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset values read back
        apb_xfer(32'h10, 1'b0, 0, 4'h0, "rd10");
        apb_xfer(32'h14, 1'b0, 0, 4'h0, "rd14");
        apb_xfer(32'h18, 1'b0, 0, 4'h0, "rd18");
        apb_xfer(32'h1C, 1'b0, 0, 4'h0, "rd1c");
        bus_idle(1);

        // Full write and readback
        apb_xfer(32'h14, 1'b1, 32'hDEAD_BEEF, 4'hF, "wr14");
        check("wr14/pulse_const", 128'(wr_pulse), 128'(4'b0010));
        check("wr14/reg1_const", 128'(regs_out[63:32]), 128'(32'hDEAD_BEEF));
        bus_idle(1);
        apb_xfer(32'h14, 1'b0, 0, 4'h0, "rb14");

        // Partial strobes over 0xAAAAAAAA
        apb_xfer(32'h18, 1'b1, 32'hAAAA_AAAA, 4'hF, "wr18a");
        apb_xfer(32'h18, 1'b1, 32'h1122_3344, 4'b0101, "wr18b");
        check("wr18b/reg2_const", 128'(regs_out[95:64]), 128'(32'hAA22_AA44));
        apb_xfer(32'h18, 1'b0, 0, 4'h0, "rb18");
        bus_idle(1);

        // Zero strobe still pulses; misses are dropped
        apb_xfer(32'h10, 1'b1, 32'hFFFF_FFFF, 4'h0, "wr10_nostrb");
        apb_xfer(32'h20, 1'b1, 32'h5, 4'hF, "miss20");
        apb_xfer(32'h12, 1'b1, 32'h5, 4'hF, "miss12");
        apb_xfer(32'h0C, 1'b0, 0, 4'h0, "miss0c");
        bus_idle(1);

        // Setup-less access (psel with penable) in IDLE is ignored
        psel = 1'b1; penable = 1'b1; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h77; pstrb = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("nosetup/pready", 128'(pready), 128'(0));
        end
        check("nosetup/regs_out", 128'(regs_out), model_flat());
        bus_idle(1);

        // Abort after one access cycle
        psel = 1'b1; penable = 1'b0; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h1234; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        check("abort/pready0", 128'(pready), 128'(0));
        @(posedge clk); #1;
        check("abort/pready1", 128'(pready), 128'(0));
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        check("abort/wr_pulse", 128'(wr_pulse), 128'(0));
        check("abort/regs_out", 128'(regs_out), model_flat());
        apb_xfer(32'h10, 1'b0, 0, 4'h0, "abort_rd10");
        bus_idle(1);

        // Reset during the wait count of a write to reg3
        apb_xfer(32'h1C, 1'b1, 32'hCAFE_F00D, 4'hF, "wr1c");
        bus_idle(1);
        psel = 1'b1; penable = 1'b0; paddr = 32'h1C; pwrite = 1'b1; pwdata = 32'h1357_9BDF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("midrst/pready", 128'(pready), 128'(0));
        check("midrst/pslverr", 128'(pslverr), 128'(0));
        check("midrst/prdata", 128'(prdata), 128'(0));
        check("midrst/wr_pulse", 128'(wr_pulse), 128'(0));
        check("midrst/regs_out", 128'(regs_out), 128'(0));
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        apb_xfer(32'h1C, 1'b0, 0, 4'h0, "postrst_rd1c");
        apb_xfer(32'h1C, 1'b1, 32'h0BAD_F00D, 4'hF, "postrst_wr1c");

        // Randomized transfers, optionally back-to-back
        for (int n = 0; n < 60; n++) begin
            a = 32'($urandom_range(32'h0A, 32'h24));
            if ($urandom_range(0, 2) != 0) a = {a[31:2], 2'b00};
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            apb_xfer(a, w, d, s, "rand");
            tok = $urandom_range(0, 2);
            if (tok != 0) bus_idle(int'(tok));
        end
        bus_idle(1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
